rf_access_ctrl: RTL and testbench

Controller in front of the SRAM-backed RV32I register file (2 read ports, 1 write port, 1-cycle synchronous read). After reset it scrubs x1..x31 to zero, because SRAM contents are undefined at power-up. In normal operation it forwards same-cycle writes to reads, since the SRAM returns old data on read-during-write. It also shares the write port and read port 1 between the core pipeline and a debug requester.

---
 rtl/rf_ctrl_pkg.sv | 28 ++
 rtl/rf_bypass_port.sv | 56 +++++
 rtl/rf_access_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_rf_access_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared types and constants for the register-file access controller
//
// Purpose: FSM state and write-source encodings plus default geometry used by
//          rf_access_ctrl and rf_bypass_port.
// Ports:   none (package).

package rf_ctrl_pkg;

    localparam int NREG_DEF   = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // x0 is hard-wired to zero in RV32I.
    localparam int REG_ZERO = 0;

    typedef enum logic {
        ST_SCRUB,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        WS_NONE,
        WS_SCRUB,
        WS_CORE,
        WS_DBG
    } wsrc_e;

endpackage

// File: rtl/rf_bypass_port.sv
// rtl/rf_bypass_port.sv - one read port of the regfile with x0 masking and write forwarding
//
// Purpose: registers, alongside the SRAM's 1-cycle read, whether the address was
//          x0 and whether the same-cycle write hit it, then selects the read data.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rd_addr_i        read address presented to the SRAM this cycle
//   wr_en_i          write issued to the SRAM this cycle
//   wr_addr_i        address of that write
//   wr_data_i        data of that write
//   rf_data_i        SRAM read data (belongs to last cycle's address)
//   rd_data_o        final read data, valid the cycle after rd_addr_i

module rf_bypass_port
    import rf_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic              zero_q, zero_d;
    logic              hit_q,  hit_d;
    logic [DATA_W-1:0] fwd_q,  fwd_d;

    always_comb begin
        zero_d = (rd_addr_i == ADDR_W'(REG_ZERO));
        // The SRAM returns old contents on read-during-write, so remember the new data.
        hit_d  = wr_en_i && (wr_addr_i == rd_addr_i);
        fwd_d  = wr_data_i;
    end

    // Reset selects the x0 path so the port reads 0 until its first real read.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b1;
            hit_q  <= 1'b0;
            fwd_q  <= '0;
        end else begin
            zero_q <= zero_d;
            hit_q  <= hit_d;
            fwd_q  <= fwd_d;
        end
    end

    assign rd_data_o = zero_q ? '0 : (hit_q ? fwd_q : rf_data_i);

endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - scrub, forwarding and core/debug arbitration in front of the RV32I regfile
//
// Purpose: zero-fills x1..x(NREG-1) after reset, forwards same-cycle writes to
//          reads, and shares the write port and read port 1 with a debug requester.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   busy                             high while scrubbing (core stalls)
//   rs1Addr/rs2Addr, rs1Data/rs2Data core reads, data valid one cycle later
//   wbEn/wbAddr/wbData               core writeback
//   coreStall                        core leaves read port 1 free this cycle
//   dbgReq/dbgWe/dbgAddr/dbgWdata    debug request, held until dbgGnt
//   dbgGnt                           one-cycle grant
//   dbgRvalid/dbgRdata               debug read result, cycle after a read grant
//   rfWrEn/rfWrAddr/rfWrData         regfile write port
//   rfRd1Addr/rfRd2Addr              regfile read addresses
//   rfR1Data/rfR2Data                regfile read data (1-cycle latency)

module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic [ADDR_W-1:0] rs1Addr,
    input  logic [ADDR_W-1:0] rs2Addr,
    output logic [DATA_W-1:0] rs1Data,
    output logic [DATA_W-1:0] rs2Data,
    input  logic              wbEn,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic              coreStall,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgWdata,
    output logic              dbgGnt,
    output logic              dbgRvalid,
    output logic [DATA_W-1:0] dbgRdata,
    output logic              rfWrEn,
    output logic [ADDR_W-1:0] rfWrAddr,
    output logic [DATA_W-1:0] rfWrData,
    output logic [ADDR_W-1:0] rfRd1Addr,
    output logic [ADDR_W-1:0] rfRd2Addr,
    input  logic [DATA_W-1:0] rfR1Data,
    input  logic [DATA_W-1:0] rfR2Data
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] scrub_ptr_q, scrub_ptr_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;

    wsrc_e             wsrc;
    logic              core_wr;
    logic              dbg_wr_ok;
    logic              dbg_rd_gnt;
    logic [DATA_W-1:0] port1_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SCRUB_EN ? ST_SCRUB : ST_RUN;
            scrub_ptr_q  <= ADDR_W'(1);
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scrub_ptr_q  <= scrub_ptr_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    // Next-state logic: the scrub pointer walks 1..NREG-1, then the FSM runs.
    always_comb begin
        state_d     = state_q;
        scrub_ptr_d = scrub_ptr_q;
        if (state_q == ST_SCRUB) begin
            scrub_ptr_d = scrub_ptr_q + ADDR_W'(1);
            if (scrub_ptr_q == LAST_REG) begin
                state_d = ST_RUN;
            end
        end
    end

    // Output logic: write-source choice, debug grant and read-port-1 steering.
    // Everything is held quiet while rst is high so the reset cycle issues nothing.
    always_comb begin
        busy         = 1'b0;
        wsrc         = WS_NONE;
        dbgGnt       = 1'b0;
        core_wr      = 1'b0;
        dbg_wr_ok    = 1'b0;
        dbg_rd_gnt   = 1'b0;
        rfRd1Addr    = rs1Addr;
        if (rst) begin
            busy = SCRUB_EN;
        end else begin
            case (state_q)
                ST_SCRUB: begin
                    busy = 1'b1;
                    wsrc = WS_SCRUB;
                end
                ST_RUN: begin
                    core_wr    = wbEn && (wbAddr != ZERO_REG);
                    dbg_wr_ok  = dbgReq && dbgWe && coreStall && !core_wr;
                    // Debug reads borrow read port 1 only, so they ignore the write port.
                    dbg_rd_gnt = dbgReq && !dbgWe && coreStall;
                    if (core_wr) begin
                        wsrc = WS_CORE;
                    end else if (dbg_wr_ok) begin
                        dbgGnt = 1'b1;
                        // A debug write to x0 is acknowledged but never reaches the SRAM.
                        if (dbgAddr != ZERO_REG) begin
                            wsrc = WS_DBG;
                        end
                    end
                    if (dbg_rd_gnt) begin
                        dbgGnt    = 1'b1;
                        rfRd1Addr = dbgAddr;
                    end
                end
                default: begin
                    wsrc = WS_NONE;
                end
            endcase
        end
    end

    always_comb begin
        rfWrEn   = 1'b0;
        rfWrAddr = '0;
        rfWrData = '0;
        case (wsrc)
            WS_SCRUB: begin
                rfWrEn   = 1'b1;
                rfWrAddr = scrub_ptr_q;
                rfWrData = '0;
            end
            WS_CORE: begin
                rfWrEn   = 1'b1;
                rfWrAddr = wbAddr;
                rfWrData = wbData;
            end
            WS_DBG: begin
                rfWrEn   = 1'b1;
                rfWrAddr = dbgAddr;
                rfWrData = dbgWdata;
            end
            default: begin
                rfWrEn = 1'b0;
            end
        endcase
    end

    assign dbg_rvalid_d = dbg_rd_gnt;
    assign rfRd2Addr    = rs2Addr;

    rf_bypass_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port1 (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (rfRd1Addr),
        .wr_en_i   (rfWrEn),
        .wr_addr_i (rfWrAddr),
        .wr_data_i (rfWrData),
        .rf_data_i (rfR1Data),
        .rd_data_o (port1_data)
    );

    rf_bypass_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port2 (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (rfRd2Addr),
        .wr_en_i   (rfWrEn),
        .wr_addr_i (rfWrAddr),
        .wr_data_i (rfWrData),
        .rf_data_i (rfR2Data),
        .rd_data_o (rs2Data)
    );

    // Port 1 serves both the core and debug; the consumer is told apart by dbgRvalid.
    assign rs1Data   = port1_data;
    assign dbgRdata  = port1_data;
    assign dbgRvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb/tb_rf_access_ctrl.sv - scoreboard bench for rf_access_ctrl

module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [4:0]  rs1Addr, rs2Addr;
    logic [31:0] rs1Data, rs2Data;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        coreStall;
    logic        dbgReq, dbgWe;
    logic [4:0]  dbgAddr;
    logic [31:0] dbgWdata;
    logic        dbgGnt, dbgRvalid;
    logic [31:0] dbgRdata;
    logic        rfWrEn;
    logic [4:0]  rfWrAddr;
    logic [31:0] rfWrData;
    logic [4:0]  rfRd1Addr, rfRd2Addr;
    logic [31:0] rfR1Data = '0;
    logic [31:0] rfR2Data = '0;

    rf_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .rs1Addr   (rs1Addr),
        .rs2Addr   (rs2Addr),
        .rs1Data   (rs1Data),
        .rs2Data   (rs2Data),
        .wbEn      (wbEn),
        .wbAddr    (wbAddr),
        .wbData    (wbData),
        .coreStall (coreStall),
        .dbgReq    (dbgReq),
        .dbgWe     (dbgWe),
        .dbgAddr   (dbgAddr),
        .dbgWdata  (dbgWdata),
        .dbgGnt    (dbgGnt),
        .dbgRvalid (dbgRvalid),
        .dbgRdata  (dbgRdata),
        .rfWrEn    (rfWrEn),
        .rfWrAddr  (rfWrAddr),
        .rfWrData  (rfWrData),
        .rfRd1Addr (rfRd1Addr),
        .rfRd2Addr (rfRd2Addr),
        .rfR1Data  (rfR1Data),
        .rfR2Data  (rfR2Data)
    );

    always #5 clk = ~clk;

    // SRAM model: 1-cycle synchronous read, old data on read-during-write,
    // non-zero garbage at power-up.
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hBAD0_0000 + i;
    end
    always @(posedge clk) begin
        if (rfWrEn === 1'b1) mem[rfWrAddr] <= rfWrData;
        rfR1Data <= mem[rfRd1Addr];
        rfR2Data <= mem[rfRd2Addr];
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard queues.
    typedef struct { int cyc; int sig; logic [31:0] val; } chk_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    chk_t        chk_q [$];
    wr_t         wr_q  [$];
    logic [31:0] rd_q  [$];

    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;
    logic reported = 1'b0;

    function automatic logic [31:0] sample(int sig);
        case (sig)
            0: return {31'b0, busy};
            1: return rs1Data;
            2: return rs2Data;
            3: return {31'b0, dbgGnt};
            4: return {31'b0, dbgRvalid};
            5: return dbgRdata;
            6: return {31'b0, rfWrEn};
            7: return {27'b0, rfRd1Addr};
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            0: return "busy";
            1: return "rs1Data";
            2: return "rs2Data";
            3: return "dbgGnt";
            4: return "dbgRvalid";
            5: return "dbgRdata";
            6: return "rfWrEn";
            7: return "rfRd1Addr";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(int c, int s, logic [31:0] v);
        chk_t e;
        e.cyc = c; e.sig = s; e.val = v;
        chk_q.push_back(e);
    endtask

    task automatic push_wr(logic [4:0] a, logic [31:0] d);
        wr_t w;
        w.a = a; w.d = d;
        wr_q.push_back(w);
    endtask

    // Monitor: compares at the falling edge, away from the active edge.
    logic [31:0] act;
    wr_t         wexp;
    logic [31:0] rexp;
    always @(negedge clk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc <= cyc_cnt) begin
                checks++;
                act = sample(chk_q[i].sig);
                if (chk_q[i].cyc < cyc_cnt || act !== chk_q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got %h want %h",
                             sig_name(chk_q[i].sig), chk_q[i].cyc, act, chk_q[i].val);
                end
                chk_q.delete(i);
            end
        end
        if (rfWrEn === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc %0d: got addr %0d data %h want none",
                         cyc_cnt, rfWrAddr, rfWrData);
            end else begin
                wexp = wr_q.pop_front();
                if (rfWrAddr !== wexp.a || rfWrData !== wexp.d) begin
                    errors++;
                    $display("FAIL write cyc %0d: got addr %0d data %h want addr %0d data %h",
                             cyc_cnt, rfWrAddr, rfWrData, wexp.a, wexp.d);
                end
            end
        end
        if (dbgRvalid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dbg_read cyc %0d: got %h want none", cyc_cnt, dbgRdata);
            end else begin
                rexp = rd_q.pop_front();
                if (dbgRdata !== rexp) begin
                    errors++;
                    $display("FAIL dbg_read cyc %0d: got %h want %h", cyc_cnt, dbgRdata, rexp);
                end
            end
        end
        if (done && !reported) begin
            checks++;
            if (chk_q.size() + wr_q.size() + rd_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d checks %0d writes %0d reads pending want 0",
                         chk_q.size(), wr_q.size(), rd_q.size());
            end
            reported = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scrub_noise(int i);
        wbEn      = 1'b1;
        wbAddr    = 5'd9;
        wbData    = 32'hFFFF_0000 + i;
        dbgReq    = 1'b1;
        dbgWe     = 1'b1;
        dbgAddr   = 5'd4;
        dbgWdata  = 32'h4444_4444;
        coreStall = 1'b1;
        rs1Addr   = 5'(i);
        rs2Addr   = 5'd0;
    endtask

    task automatic idle_inputs();
        wbEn = 1'b0; wbAddr = '0; wbData = '0;
        dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWdata = '0;
        coreStall = 1'b0; rs1Addr = '0; rs2Addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset state, rst still high.
        step();
        push(cyc_cnt, 0, 32'd1);
        push(cyc_cnt, 6, 32'd0);
        push(cyc_cnt, 3, 32'd0);
        push(cyc_cnt, 4, 32'd0);
        push(cyc_cnt, 1, 32'd0);
        push(cyc_cnt, 2, 32'd0);
        push(cyc_cnt, 5, 32'd0);
        step();
        rst = 1'b0;

        // Partial scrub, then reset mid-scrub.
        for (int i = 1; i <= 10; i++) begin
            scrub_noise(i);
            push_wr(5'(i), 32'd0);
            push(cyc_cnt, 0, 32'd1);
            push(cyc_cnt, 3, 32'd0);
            step();
        end
        rst = 1'b1;
        push(cyc_cnt, 0, 32'd1);
        push(cyc_cnt, 6, 32'd0);
        push(cyc_cnt, 3, 32'd0);
        step();
        rst = 1'b0;

        // Full restarted scrub: 31 writes x1..x31 of zero, core and debug ignored.
        for (int i = 1; i <= 31; i++) begin
            scrub_noise(i);
            push_wr(5'(i), 32'd0);
            push(cyc_cnt, 0, 32'd1);
            push(cyc_cnt, 3, 32'd0);
            push(cyc_cnt + 1, 1, 32'd0);
            step();
        end
        idle_inputs();
        push(cyc_cnt, 0, 32'd0);
        push(cyc_cnt, 6, 32'd0);
        step();

        // Forwarding: write x5 and read it on both ports in the same cycle.
        wbEn = 1'b1; wbAddr = 5'd5; wbData = 32'hDEAD_BEEF;
        rs1Addr = 5'd5; rs2Addr = 5'd5;
        push_wr(5'd5, 32'hDEAD_BEEF);
        push(cyc_cnt, 6, 32'd1);
        push(cyc_cnt + 1, 1, 32'hDEAD_BEEF);
        push(cyc_cnt + 1, 2, 32'hDEAD_BEEF);
        step();
        wbEn = 1'b0;
        push(cyc_cnt + 1, 1, 32'hDEAD_BEEF);
        step();

        // x0: write discarded, read returns 0 despite SRAM garbage.
        wbEn = 1'b1; wbAddr = 5'd0; wbData = 32'h0000_1234;
        rs1Addr = 5'd0; rs2Addr = 5'd5;
        push(cyc_cnt, 6, 32'd0);
        push(cyc_cnt + 1, 1, 32'd0);
        push(cyc_cnt + 1, 2, 32'hDEAD_BEEF);
        step();

        // Arbitration: core writeback wins over debug write.
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 5'd7; dbgWdata = 32'hA5A5_A5A5;
        coreStall = 1'b1;
        wbEn = 1'b1; wbAddr = 5'd3; wbData = 32'h0000_0033;
        push_wr(5'd3, 32'h0000_0033);
        push(cyc_cnt, 3, 32'd0);
        push(cyc_cnt, 6, 32'd1);
        step();
        wbEn = 1'b0;
        push_wr(5'd7, 32'hA5A5_A5A5);
        push(cyc_cnt, 3, 32'd1);
        step();
        // Debug write to x0: granted, discarded.
        dbgAddr = 5'd0;
        push(cyc_cnt, 3, 32'd1);
        push(cyc_cnt, 6, 32'd0);
        step();

        // Debug read of x7.
        dbgWe = 1'b0; dbgAddr = 5'd7; rs1Addr = 5'd2;
        rd_q.push_back(32'hA5A5_A5A5);
        push(cyc_cnt, 3, 32'd1);
        push(cyc_cnt, 7, 32'd7);
        push(cyc_cnt + 1, 4, 32'd1);
        step();
        // Debug read alongside a core writeback to the same register: forwarded.
        wbEn = 1'b1; wbAddr = 5'd7; wbData = 32'h0000_0077;
        push_wr(5'd7, 32'h0000_0077);
        rd_q.push_back(32'h0000_0077);
        push(cyc_cnt, 3, 32'd1);
        push(cyc_cnt + 1, 4, 32'd1);
        step();
        // Core using port 1: no grant, port stays with the core.
        wbEn = 1'b0; coreStall = 1'b0; rs1Addr = 5'd3;
        push(cyc_cnt, 3, 32'd0);
        push(cyc_cnt, 7, 32'd3);
        push(cyc_cnt + 1, 4, 32'd0);
        push(cyc_cnt + 1, 1, 32'h0000_0033);
        step();
        idle_inputs();
        step();
        step();

        done = 1'b1;
        for (int k = 0; k < 10 && !reported; k++) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
